// File: rtl/panda_pkg.sv
// Shared types for the panda iterative divider: operation codes, FSM states
// and small op-decoding helpers.
package panda_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic logic op_is_signed(div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/panda_adder.sv
// Ripple-style adder/subtractor used for the restoring-division trial step.
module panda_adder #(
  parameter int unsigned Width = 33
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             subtract_i,
  output logic [Width-1:0] sum_o
);

  logic [Width-1:0] b_eff;

  assign b_eff = subtract_i ? ~b_i : b_i;
  assign sum_o = a_i + b_eff + Width'(subtract_i);

endmodule

// File: rtl/panda_divider.sv
// Iterative restoring divider: one quotient bit per cycle, signed/unsigned
// DIV/REM, with single-cycle handling of divide-by-zero and signed overflow.
module panda_divider
  import panda_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  input  logic [1:0]       op_i,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

  div_state_e       state, state_next;
  div_op_e          op_in, op_q;
  logic             q_neg, r_neg;
  logic [Width-1:0] b_abs, rem, quo;
  logic [CntW-1:0]  cnt;

  logic             in_signed, a_neg, b_neg, div_zero, overflow, special;
  logic [Width-1:0] a_abs_in, b_abs_in, special_res;
  logic [Width:0]   shifted, trial;
  logic             trial_ok;
  logic [Width-1:0] rem_step, quo_step, rem_fix, quo_fix;

  // Request decode: magnitudes and corner cases on the incoming operands
  assign op_in       = div_op_e'(op_i);
  assign in_signed   = op_is_signed(op_in);
  assign a_neg       = in_signed & operand_a_i[Width-1];
  assign b_neg       = in_signed & operand_b_i[Width-1];
  assign a_abs_in    = a_neg ? -operand_a_i : operand_a_i;
  assign b_abs_in    = b_neg ? -operand_b_i : operand_b_i;
  assign div_zero    = (operand_b_i == '0);
  assign overflow    = in_signed && (operand_a_i == {1'b1, {(Width-1){1'b0}}})
                       && (operand_b_i == '1);
  assign special     = div_zero || overflow;
  assign special_res = div_zero ? (op_is_rem(op_in) ? operand_a_i : '1)
                                : (op_is_rem(op_in) ? '0 : operand_a_i);

  // Restoring step: trial subtract of |b| from the shifted partial remainder
  assign shifted = {rem, quo[Width-1]};

  panda_adder #(
    .Width(Width + 1)
  ) u_trial (
    .a_i       (shifted),
    .b_i       ({1'b0, b_abs}),
    .subtract_i(1'b1),
    .sum_o     (trial)
  );

  assign trial_ok = ~trial[Width];
  assign rem_step = trial_ok ? trial[Width-1:0] : shifted[Width-1:0];
  assign quo_step = {quo[Width-2:0], trial_ok};

  // Sign correction for the final result
  assign rem_fix = r_neg ? -rem : rem;
  assign quo_fix = q_neg ? -quo : quo;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid_i) state_next = special ? DONE : CALC;
      CALC: begin
        if (kill_i)                         state_next = IDLE;
        else if (cnt == CntW'(Width - 1))   state_next = FIX;
      end
      FIX:  state_next = kill_i ? IDLE : DONE;
      DONE: if (kill_i || out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      op_q        <= DIVU;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      b_abs       <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
    end else begin
      in_ready_o  <= (state_next == IDLE);
      out_valid_o <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            op_q  <= op_in;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            b_abs <= b_abs_in;
            quo   <= a_abs_in;
            rem   <= '0;
            cnt   <= '0;
            if (special) result_o <= special_res;
          end
        end
        CALC: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + CntW'(1);
        end
        FIX: begin
          if (!kill_i) result_o <= op_is_rem(op_q) ? rem_fix : quo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_panda_divider.sv
// Directed self-checking bench for panda_divider (Width = 32).
module tb_panda_divider;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  op = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

  panda_divider #(.Width(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .operand_a_i(a),
    .operand_b_i(b),
    .op_i       (op),
    .kill_i     (kill),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result)
  );

  always #5 clk = ~clk;

  // Issue one request, wait (bounded) for the result, then complete the handshake.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    res = result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    vec_t v[4];
    logic [31:0] r;
    int l;
    v[0] = '{OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu_100_7"};
    v[1] = '{OP_REMU, 32'd100, 32'd7, 32'd2, 34, "remu_100_7"};
    v[2] = '{OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34, "divu_max_1"};
    v[3] = '{OP_DIVU, 32'd7, 32'd100, 32'd0, 34, "divu_small"};
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, r, l);
      total++; if (r !== v[i].exp) begin bad++; $display("FAIL %s result got=%h exp=%h", v[i].name, r, v[i].exp); end
      total++; if (l !== v[i].lat) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", v[i].name, l, v[i].lat); end
    end
  endtask

  task automatic test_signed();
    vec_t v[5];
    logic [31:0] r;
    int l;
    v[0] = '{OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div_m7_2"};
    v[1] = '{OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "rem_m7_2"};
    v[2] = '{OP_REM,  32'd7, 32'hFFFFFFFE, 32'd1, 34, "rem_7_m2"};
    v[3] = '{OP_DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34, "div_7_m2"};
    v[4] = '{OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 34, "divu_signbits"};
    for (int i = 0; i < 5; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, r, l);
      total++; if (r !== v[i].exp) begin bad++; $display("FAIL %s result got=%h exp=%h", v[i].name, r, v[i].exp); end
      total++; if (l !== v[i].lat) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", v[i].name, l, v[i].lat); end
    end
  endtask

  task automatic test_special();
    vec_t v[6];
    logic [31:0] r;
    int l;
    v[0] = '{OP_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 1, "div_5_0"};
    v[1] = '{OP_REMU, 32'd5, 32'd0, 32'd5, 1, "remu_5_0"};
    v[2] = '{OP_REM,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1, "rem_m7_0"};
    v[3] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf"};
    v[4] = '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_ovf"};
    v[5] = '{OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34, "divu_no_ovf"};
    for (int i = 0; i < 6; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, r, l);
      total++; if (r !== v[i].exp) begin bad++; $display("FAIL %s result got=%h exp=%h", v[i].name, r, v[i].exp); end
      total++; if (l !== v[i].lat) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", v[i].name, l, v[i].lat); end
    end
  endtask

  task automatic test_stall_kill();
    logic [31:0] r;
    int l;
    int guard;
    bit seen_valid;
    // Stall in DONE with out_ready low
    op = OP_DIVU; a = 32'd1000; b = 32'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_reach_done got=%b exp=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (result !== 32'd100 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold cyc=%0d result=%h valid=%b ready=%b exp=00000064/1/0", i, result, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release valid=%b ready=%b exp=0/1", out_valid, in_ready);
    end
    // Kill in CALC cycle 10
    seen_valid = 1'b0;
    op = OP_DIVU; a = 32'd500; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (out_valid) seen_valid = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL kill_busy ready=%b exp=0", in_ready); end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL kill_idle ready=%b valid=%b exp=1/0", in_ready, out_valid);
    end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen_valid = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (seen_valid !== 1'b0) begin bad++; $display("FAIL kill_no_result got=%b exp=0", seen_valid); end
    do_op(OP_DIVU, 32'd100, 32'd7, r, l);
    total++; if (r !== 32'd14 || l !== 34) begin bad++; $display("FAIL kill_next result=%h lat=%0d exp=0000000e/34", r, l); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int l;
    op = OP_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
      bad++; $display("FAIL reset_mid ready=%b valid=%b result=%h exp=1/0/00000000", in_ready, out_valid, result);
    end
    rst = 1'b0;
    do_op(OP_DIVU, 32'd1, 32'd1, r, l);
    total++; if (r !== 32'd1 || l !== 34) begin bad++; $display("FAIL reset_next result=%h lat=%0d exp=00000001/34", r, l); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_stall_kill();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
